// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Bundles the producer handshake, the shared FIFO write port and the
// arbiter status outputs. The arbiter connects through the slave modport,
// while the producer/FIFO side (or a testbench) uses the master modport.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int GNT_W  = $clog2(N_REQ)
);

  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_rdy;
  logic                    fifo_wr_en;
  logic [DATA_W-1:0]       fifo_din;
  logic                    fifo_full;
  logic [GNT_W-1:0]        gnt_id;
  logic [CNT_W-1:0]        wr_count;

  modport master (
    output req_vld,
    output req_data,
    output fifo_full,
    input  req_rdy,
    input  fifo_wr_en,
    input  fifo_din,
    input  gnt_id,
    input  wr_count
  );

  modport slave (
    input  req_vld,
    input  req_data,
    input  fifo_full,
    output req_rdy,
    output fifo_wr_en,
    output fifo_din,
    output gnt_id,
    output wr_count
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one synchronous FIFO write port among N_REQ
// valid/ready producers. At most one beat is accepted per cycle, and the FIFO
// write is issued combinationally in the same cycle as the handshake. A
// running count of accepted beats is kept in wr_count.
//
// Optional feature macro: FIFO_ARB_BURST_EN
//   When defined, the current owner may keep the port for up to MAX_BURST
//   consecutive beats before round robin resumes. When undefined, every beat
//   is arbitrated round robin, and MAX_BURST does not exist.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
`ifdef FIFO_ARB_BURST_EN
  parameter int MAX_BURST = 4,
`endif
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int GNT_W = $clog2(N_REQ);

  logic [GNT_W-1:0] rr_ptr;
  logic [GNT_W-1:0] rr_winner;
  logic             rr_found;
  logic [GNT_W-1:0] winner;
  logic             grant;
  logic [CNT_W-1:0] wr_count_q;

  // Returns (base + off) mod N_REQ. This also covers N_REQ values that are
  // not powers of two.
  function automatic logic [GNT_W-1:0] wrap_idx(input logic [GNT_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return GNT_W'(sum);
  endfunction

  // Circular scan for the first valid requester starting at rr_ptr. The loop
  // walks from the farthest offset to the nearest offset, so the closest
  // valid requester is the last one written and therefore wins.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_vld[wrap_idx(rr_ptr, k)]) begin
        rr_found  = 1'b1;
        rr_winner = wrap_idx(rr_ptr, k);
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int BC_W = $clog2(MAX_BURST + 1);

  logic [GNT_W-1:0] burst_own;
  logic [BC_W-1:0]  burst_cnt;
  logic             burst_hold;

  // The owner keeps the port only while it is still requesting and has
  // beats left in its allowance. A zero count means no burst is in progress.
  assign burst_hold = (burst_cnt != '0) && bus.req_vld[burst_own] &&
                      (burst_cnt < BC_W'(MAX_BURST));

  // Pick the winner. An active burst overrides the round-robin pointer.
  always_comb begin
    winner = burst_hold ? burst_own : rr_winner;
    grant  = !rst && !bus.fifo_full && rr_found;
  end

  // Track the burst owner and its beat count. A full FIFO freezes the burst,
  // and a burst that can no longer continue releases the port immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_own <= '0;
      burst_cnt <= '0;
    end else if (!bus.fifo_full) begin
      if (burst_hold) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else if (rr_found) begin
        burst_own <= rr_winner;
        burst_cnt <= BC_W'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end
`else
  // Pure per-beat round robin. The first valid requester from rr_ptr wins.
  always_comb begin
    winner = rr_winner;
    grant  = !rst && !bus.fifo_full && rr_found;
  end
`endif

  // Advance priority past the winner and count accepted beats. Nothing moves
  // on idle cycles or stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      wr_count_q <= '0;
    end else if (grant) begin
      rr_ptr     <= wrap_idx(winner, 1);
      wr_count_q <= wr_count_q + 1'b1;
    end
  end

  // Drive the handshake and the FIFO write port for the winning requester.
  // Every output stays at zero when there is no grant, including during reset.
  always_comb begin
    bus.req_rdy    = '0;
    bus.fifo_wr_en = 1'b0;
    bus.fifo_din   = '0;
    bus.gnt_id     = '0;
    if (grant) begin
      bus.req_rdy[winner] = 1'b1;
      bus.fifo_wr_en      = 1'b1;
      bus.fifo_din        = bus.req_data[int'(winner) * DATA_W +: DATA_W];
      bus.gnt_id          = winner;
    end
  end

  assign bus.wr_count = wr_count_q;

endmodule
